// File: rtl/hamming_pkg.sv
// Shared extended-Hamming (SEC-DED) helpers: code geometry, bit placement, encoder.
// Hamming positions are 1-based; codeword bit i holds position i+1, and the overall parity bit is the MSB.
package hamming_pkg;

   localparam int MAX_DATA_W = 64;
   localparam int MAX_CODE_W = 72;

   typedef enum logic [1:0] {
      CLEAN = 2'd0,
      SEC   = 2'd1,
      DED   = 2'd2
   } dec_status_e;

   function automatic int calc_par_w(input int dw);
      int p;
      p = 0;
      for (int q = 1; q < 8; q++) begin
         if (p == 0 && (1 << q) >= dw + q + 1) p = q;
      end
      return p;
   endfunction

   function automatic int calc_code_w(input int dw);
      return dw + calc_par_w(dw) + 1;
   endfunction

   function automatic logic is_pow2(input int pos);
      return (pos != 0) && ((pos & (pos - 1)) == 0);
   endfunction

   // Codeword index of data bit k: the k-th Hamming position that is not a power of two.
   function automatic int data_pos(input int k);
      int cnt;
      int idx;
      cnt = 0;
      idx = 0;
      for (int pos = 1; pos < MAX_CODE_W; pos++) begin
         if (!is_pow2(pos)) begin
            if (cnt == k) idx = pos - 1;
            cnt++;
         end
      end
      return idx;
   endfunction

   function automatic logic [MAX_CODE_W-1:0] encode(input logic [MAX_DATA_W-1:0] data, input int dw);
      logic [MAX_CODE_W-1:0] cw;
      logic [7:0]            syn;
      int                    pw;
      pw  = calc_par_w(dw);
      cw  = '0;
      syn = '0;
      for (int k = 0; k < MAX_DATA_W; k++) begin
         if (k < dw) cw[data_pos(k)] = data[k];
      end
      for (int i = 0; i < MAX_CODE_W; i++) begin
         if (cw[i]) syn = syn ^ 8'(i + 1);
      end
      for (int j = 0; j < 7; j++) begin
         if (j < pw) cw[(1 << j) - 1] = syn[j];
      end
      cw[dw + pw] = ^cw;
      return cw;
   endfunction

endpackage

// File: rtl/hamming_secded_dec.sv
// Combinational SEC-DED decoder: syndrome, overall parity check, single-bit correction.
module hamming_secded_dec
   import hamming_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [calc_code_w(DATA_W)-1:0] cw,
   output logic [DATA_W-1:0]              data,
   output dec_status_e                    status,
   output logic [calc_par_w(DATA_W)-1:0]  syndrome
);
   localparam int PAR_W  = calc_par_w(DATA_W);
   localparam int CODE_W = calc_code_w(DATA_W);

   logic [CODE_W-1:0] fixed;
   logic              par_bad;
   int                flip_idx;

   always_comb begin
      syndrome = '0;
      for (int i = 0; i < CODE_W - 1; i++) begin
         if (cw[i]) syndrome = syndrome ^ PAR_W'(i + 1);
      end
      par_bad  = ^cw;
      fixed    = cw;
      status   = CLEAN;
      flip_idx = int'(syndrome) - 1;
      if (par_bad) begin
         status = SEC;
         // A syndrome beyond the last position can only come from a multi-bit error.
         if (syndrome != '0) begin
            if (int'(syndrome) < CODE_W) fixed[flip_idx] = ~fixed[flip_idx];
            else                         status = DED;
         end
      end else if (syndrome != '0) begin
         status = DED;
      end
      for (int k = 0; k < DATA_W; k++) begin
         data[k] = fixed[data_pos(k)];
      end
   end

endmodule

// File: rtl/hamming_secded_counter.sv
// Up/down counter whose state lives as a SEC-DED codeword, corrected and re-encoded every cycle.
module hamming_secded_counter
   import hamming_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int SATURATE = 0,
   parameter int ERRCNT_W = 8
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           enable,
   input  logic                           up_dn,
   input  logic                           load,
   input  logic [DATA_W-1:0]              load_val,
   input  logic                           inj_valid,
   input  logic [calc_code_w(DATA_W)-1:0] inj_mask,
   input  logic                           clr_err,
   output logic [DATA_W-1:0]              counter,
   output logic                           wrap,
   output logic                           sec_err,
   output logic                           ded_err,
   output logic [ERRCNT_W-1:0]            sec_count
);
   localparam int PAR_W  = calc_par_w(DATA_W);
   localparam int CODE_W = calc_code_w(DATA_W);

   logic [CODE_W-1:0]   cw_q, cw_d;
   logic                wrap_q, wrap_d;
   logic                ded_err_q, ded_err_d;
   logic [ERRCNT_W-1:0] sec_count_q, sec_count_d;
   logic [DATA_W-1:0]   dec_data, step_val;
   logic [PAR_W-1:0]    dec_syn;
   dec_status_e         dec_status;
   logic                at_limit;

   hamming_secded_dec #(.DATA_W(DATA_W)) u_dec (
      .cw       (cw_q),
      .data     (dec_data),
      .status   (dec_status),
      .syndrome (dec_syn)
   );

   function automatic logic [CODE_W-1:0] enc(input logic [DATA_W-1:0] v);
      logic [MAX_CODE_W-1:0] full;
      full = encode(MAX_DATA_W'(v), DATA_W);
      return full[CODE_W-1:0];
   endfunction

   always_comb begin
      at_limit = up_dn ? (dec_data == '1) : (dec_data == '0);
      step_val = up_dn ? dec_data + DATA_W'(1) : dec_data - DATA_W'(1);
      if (at_limit && SATURATE != 0) step_val = dec_data;

      cw_d      = cw_q;
      wrap_d    = 1'b0;
      ded_err_d = ded_err_q || (dec_status == DED);
      if (load) begin
         cw_d      = enc(load_val);
         ded_err_d = 1'b0;
      end else if (dec_status == DED || ded_err_q) begin
         // Uncorrectable state: freeze rather than count from garbage.
         cw_d = cw_q;
      end else if (enable) begin
         cw_d   = enc(step_val);
         wrap_d = at_limit && (SATURATE == 0);
      end else if (dec_status == SEC) begin
         cw_d = enc(dec_data);
      end
      if (clr_err) ded_err_d = 1'b0;
      if (inj_valid) cw_d = cw_d ^ inj_mask;

      sec_count_d = sec_count_q;
      if (clr_err)                                        sec_count_d = '0;
      else if (dec_status == SEC && sec_count_q != '1)    sec_count_d = sec_count_q + ERRCNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cw_q        <= '0;
         wrap_q      <= 1'b0;
         ded_err_q   <= 1'b0;
         sec_count_q <= '0;
      end else begin
         cw_q        <= cw_d;
         wrap_q      <= wrap_d;
         ded_err_q   <= ded_err_d;
         sec_count_q <= sec_count_d;
      end
   end

   assign counter   = dec_data;
   assign wrap      = wrap_q;
   assign sec_err   = (dec_status == SEC);
   assign ded_err   = ded_err_q;
   assign sec_count = sec_count_q;

endmodule

// File: tb/tb_hamming_secded_counter.sv
// Directed + randomized bench for two counter configurations against an error-pattern level model.
module tb_hamming_secded_counter;
   localparam int AW = 32, ACW = 39, BW = 8, BCW = 13;

   logic clk = 1'b0, rst = 1'b0;
   logic a_en, a_up, a_ld, a_inj, a_clr;
   logic [AW-1:0]  a_lv, a_cnt;
   logic [ACW-1:0] a_im;
   logic a_wrap, a_sec, a_ded;
   logic [7:0] a_sc;
   logic b_en, b_up, b_ld, b_inj, b_clr;
   logic [BW-1:0]  b_lv, b_cnt;
   logic [BCW-1:0] b_im;
   logic b_wrap, b_sec, b_ded;
   logic [7:0] b_sc;

   typedef struct {
      int          dw;
      bit          sat;
      logic [63:0] v;
      logic [63:0] em;
      bit          ded;
      int          cnt;
      bit          wrap;
   } mdl_t;

   mdl_t ma, mb;
   int tests = 0, fails = 0;

   hamming_secded_counter #(.DATA_W(AW), .SATURATE(0), .ERRCNT_W(8)) dut_a (
      .clk(clk), .rst(rst), .enable(a_en), .up_dn(a_up), .load(a_ld), .load_val(a_lv),
      .inj_valid(a_inj), .inj_mask(a_im), .clr_err(a_clr), .counter(a_cnt), .wrap(a_wrap),
      .sec_err(a_sec), .ded_err(a_ded), .sec_count(a_sc));

   hamming_secded_counter #(.DATA_W(BW), .SATURATE(1), .ERRCNT_W(8)) dut_b (
      .clk(clk), .rst(rst), .enable(b_en), .up_dn(b_up), .load(b_ld), .load_val(b_lv),
      .inj_valid(b_inj), .inj_mask(b_im), .clr_err(b_clr), .counter(b_cnt), .wrap(b_wrap),
      .sec_err(b_sec), .ded_err(b_ded), .sec_count(b_sc));

   always #5 clk = ~clk;

   function automatic int par_w(int dw);
      int p = 1;
      while ((1 << p) < dw + p + 1) p++;
      return p;
   endfunction

   // Data bits disturbed by an error pattern when the decoder leaves it uncorrected.
   function automatic logic [63:0] mdat(logic [63:0] em, int dw);
      logic [63:0] r = '0;
      int k = 0;
      for (int pos = 1; pos <= dw + par_w(dw); pos++) begin
         if ((pos & (pos - 1)) != 0) begin
            if (em[pos-1]) r[k] = 1'b1;
            k++;
         end
      end
      return r;
   endfunction

   function automatic logic [63:0] exp_cnt(mdl_t m);
      if ($countones(m.em) == 2) return m.v ^ mdat(m.em, m.dw);
      return m.v;
   endfunction

   function automatic mdl_t nxt(mdl_t m, bit r, bit en, bit up, bit ld, logic [63:0] lv,
                                bit inj, logic [63:0] im, bit clr);
      mdl_t n = m;
      logic [63:0] maxv = (64'd1 << m.dw) - 64'd1;
      int p = $countones(m.em);
      n.wrap = 1'b0;
      if (r) begin
         n.v = '0; n.em = '0; n.ded = 1'b0; n.cnt = 0;
         return n;
      end
      if (clr)                       n.cnt = 0;
      else if (p == 1 && n.cnt < 255) n.cnt = n.cnt + 1;
      if (ld) begin
         n.v = lv & maxv; n.em = '0; n.ded = 1'b0;
      end else if (p == 2 || m.ded) begin
         if (p == 2) n.ded = 1'b1;
      end else if (en) begin
         if (up) begin
            if (m.v == maxv) begin
               if (!m.sat) begin n.v = '0; n.wrap = 1'b1; end
            end else n.v = m.v + 64'd1;
         end else begin
            if (m.v == 64'd0) begin
               if (!m.sat) begin n.v = maxv; n.wrap = 1'b1; end
            end else n.v = m.v - 64'd1;
         end
         n.em = '0;
      end else if (p == 1) begin
         n.em = '0;
      end
      if (clr) n.ded = 1'b0;
      if (inj) n.em = n.em ^ im;
      return n;
   endfunction

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all();
      chk("a_counter", 64'(a_cnt), exp_cnt(ma));
      chk("a_wrap", 64'(a_wrap), 64'(ma.wrap));
      chk("a_sec_err", 64'(a_sec), 64'($countones(ma.em) == 1));
      chk("a_ded_err", 64'(a_ded), 64'(ma.ded));
      chk("a_sec_count", 64'(a_sc), 64'(ma.cnt));
      chk("b_counter", 64'(b_cnt), exp_cnt(mb));
      chk("b_wrap", 64'(b_wrap), 64'(mb.wrap));
      chk("b_sec_err", 64'(b_sec), 64'($countones(mb.em) == 1));
      chk("b_ded_err", 64'(b_ded), 64'(mb.ded));
      chk("b_sec_count", 64'(b_sc), 64'(mb.cnt));
   endtask

   task automatic cyc();
      mdl_t na, nb;
      na = nxt(ma, rst, a_en, a_up, a_ld, 64'(a_lv), a_inj, 64'(a_im), a_clr);
      nb = nxt(mb, rst, b_en, b_up, b_ld, 64'(b_lv), b_inj, 64'(b_im), b_clr);
      @(posedge clk);
      #1;
      ma = na;
      mb = nb;
      chk_all();
   endtask

   task automatic idle();
      a_en = 0; a_up = 1; a_ld = 0; a_lv = '0; a_inj = 0; a_im = '0; a_clr = 0;
      b_en = 0; b_up = 1; b_ld = 0; b_lv = '0; b_inj = 0; b_im = '0; b_clr = 0;
   endtask

   initial begin
      mdl_t trial;
      ma = '{dw: AW, sat: 1'b0, v: '0, em: '0, ded: 1'b0, cnt: 0, wrap: 1'b0};
      mb = '{dw: BW, sat: 1'b1, v: '0, em: '0, ded: 1'b0, cnt: 0, wrap: 1'b0};
      idle();
      rst = 1; cyc(); rst = 0;
      chk("reset_counter", 64'(a_cnt), 64'd0);

      a_en = 1; repeat (20) cyc(); chk("count_20", 64'(a_cnt), 64'd20);
      a_en = 0; repeat (9) cyc();  chk("hold_20", 64'(a_cnt), 64'd20);
      a_en = 1; repeat (5) cyc();  chk("count_25", 64'(a_cnt), 64'd25);
      a_en = 0;

      a_inj = 1; a_im = '0; a_im[3] = 1'b1; cyc(); a_inj = 0;
      chk("sec_visible", 64'(a_sec), 64'd1);
      chk("sec_corrected", 64'(a_cnt), 64'd25);
      cyc();
      chk("scrubbed", 64'(a_sec), 64'd0);
      chk("sec_count_1", 64'(a_sc), 64'd1);

      a_inj = 1; a_im = '0; a_im[0] = 1'b1; a_im[5] = 1'b1; a_en = 1; cyc(); a_inj = 0;
      cyc();
      chk("ded_set", 64'(a_ded), 64'd1);
      repeat (3) cyc();
      chk("ded_frozen", 64'(a_cnt), 64'd30);
      a_en = 0; a_ld = 1; a_lv = 32'd100; cyc(); a_ld = 0;
      chk("load_100", 64'(a_cnt), 64'd100);
      chk("load_clears_ded", 64'(a_ded), 64'd0);
      a_en = 1; repeat (3) cyc(); chk("resume", 64'(a_cnt), 64'd103);
      a_en = 0;

      a_ld = 1; a_lv = 32'hFFFF_FFFE; cyc(); a_ld = 0; a_en = 1;
      cyc(); chk("top", 64'(a_cnt), 64'hFFFF_FFFF);
      cyc(); chk("wrap_up", 64'(a_wrap), 64'd1);
      a_up = 0;
      cyc(); chk("wrap_dn_val", 64'(a_cnt), 64'hFFFF_FFFF);
      chk("wrap_dn", 64'(a_wrap), 64'd1);
      cyc(); chk("wrap_pulse_end", 64'(a_wrap), 64'd0);
      a_en = 0; a_up = 1;

      b_ld = 1; b_lv = 8'd254; cyc(); b_ld = 0; b_en = 1; b_up = 1;
      repeat (3) cyc();
      chk("sat_hi", 64'(b_cnt), 64'd255);
      chk("sat_no_wrap", 64'(b_wrap), 64'd0);
      b_en = 0; b_ld = 1; b_lv = 8'd0; cyc(); b_ld = 0; b_en = 1; b_up = 0;
      cyc(); chk("sat_lo", 64'(b_cnt), 64'd0);
      b_en = 0;

      a_ld = 1; a_lv = 32'd6; cyc(); a_ld = 0; a_en = 1;
      cyc(); chk("at_7", 64'(a_cnt), 64'd7);
      rst = 1; a_inj = 1; a_im = '0; a_im[2] = 1'b1; cyc(); rst = 0; a_inj = 0;
      chk("rst_counter", 64'(a_cnt), 64'd0);
      chk("rst_sec_count", 64'(a_sc), 64'd0);
      idle();

      for (int n = 0; n < 600; n++) begin
         rst   = ($urandom_range(0, 59) == 0);
         a_en  = ($urandom_range(0, 3) != 0);
         a_up  = 1'($urandom);
         a_ld  = ($urandom_range(0, 15) == 0);
         case ($urandom_range(0, 3))
            0:       a_lv = '1;
            1:       a_lv = 32'hFFFF_FFFE;
            2:       a_lv = 32'($urandom_range(0, 1));
            default: a_lv = $urandom;
         endcase
         a_clr = ($urandom_range(0, 19) == 0);
         a_inj = ($urandom_range(0, 5) == 0);
         a_im  = '0;
         a_im[$urandom_range(0, ACW - 1)] = 1'b1;
         if ($urandom_range(0, 3) == 0) a_im[$urandom_range(0, ACW - 1)] = 1'b1;
         trial = nxt(ma, rst, a_en, a_up, a_ld, 64'(a_lv), a_inj, 64'(a_im), a_clr);
         if ($countones(trial.em) > 2) a_inj = 0;

         b_en  = ($urandom_range(0, 3) != 0);
         b_up  = 1'($urandom);
         b_ld  = ($urandom_range(0, 11) == 0);
         b_lv  = ($urandom_range(0, 1) == 0) ? 8'($urandom) : ($urandom_range(0, 1) == 0 ? 8'd255 : 8'd0);
         b_clr = ($urandom_range(0, 19) == 0);
         b_inj = ($urandom_range(0, 5) == 0);
         b_im  = '0;
         b_im[$urandom_range(0, BCW - 1)] = 1'b1;
         if ($urandom_range(0, 3) == 0) b_im[$urandom_range(0, BCW - 1)] = 1'b1;
         trial = nxt(mb, rst, b_en, b_up, b_ld, 64'(b_lv), b_inj, 64'(b_im), b_clr);
         if ($countones(trial.em) > 2) b_inj = 0;
         cyc();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
